rram_host_issuer: RTL and testbench

Host-side writer/reader for one RRAM crossbar core's FIFO interface. Accepts host commands and write data over valid/ready streams and pushes them into the core's instruction FIFO and input-data FIFO, which the core controller FSM pops. It also drains the core's output-data FIFO and hands results back to the host. It sits between the host/bus fabric and the three per-core FIFOs.

---
 rtl/rram_host_issuer.sv | 137 +++++++++++++
 tb/tb_rram_host_issuer.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rram_host_issuer.sv
// ============================================================================
// rram_host_issuer -- feeds one RRAM core's instruction/input FIFOs from host
// streams and drains its output FIFO. Optional: RRAM_ISSUER_STATS_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module rram_host_issuer #(
  parameter int INSTR_WIDTH   = 4,
  parameter int OPCODE_WIDTH  = 16,
  parameter int DATAIN_WIDTH  = 64,
  parameter int DATAOUT_WIDTH = 64,
  parameter int MAX_BURST     = 16,
  localparam int NW           = $clog2(MAX_BURST + 1)
) (
  input  logic                                CLK,
  input  logic                                RST_N,
  input  logic                                cmd_valid,
  output logic                                cmd_ready,
  input  logic [INSTR_WIDTH-1:0]              cmd_instr,
  input  logic [OPCODE_WIDTH-1:0]             cmd_opcode,
  input  logic [NW-1:0]                       cmd_nwords,
  input  logic                                wdata_valid,
  output logic                                wdata_ready,
  input  logic [DATAIN_WIDTH-1:0]             wdata,
  output logic                                push_n_instFIFO,
  input  logic                                full_instFIFO,
  output logic [INSTR_WIDTH+OPCODE_WIDTH-1:0] din_instFIFO,
  output logic                                push_n_iFIFO,
  input  logic                                full_iFIFO,
  output logic [DATAIN_WIDTH-1:0]             din_iFIFO,
  output logic                                pop_n_oFIFO,
  input  logic                                empty_oFIFO,
  input  logic [DATAOUT_WIDTH-1:0]            dout_oFIFO,
  output logic                                rdata_valid,
  input  logic                                rdata_ready,
  output logic [DATAOUT_WIDTH-1:0]            rdata,
  output logic                                busy,
  output logic                                err_burst,
  output logic [31:0]                         stat_cmds,
  output logic [31:0]                         stat_reads
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    INSTR = 2'd2
  } state_t;

  state_t                              state;
  logic [NW-1:0]                       cnt;
  logic [INSTR_WIDTH+OPCODE_WIDTH-1:0] cmd_q;
  logic                                over;
  logic [NW-1:0]                       cnt_init;
  logic                                data_push;
  logic                                instr_push;
  logic                                pop;

  assign over     = (cmd_nwords > NW'(MAX_BURST));
  assign cnt_init = over ? NW'(MAX_BURST) : cmd_nwords;

  assign cmd_ready       = (state == IDLE);
  assign busy            = (state != IDLE);
  assign wdata_ready     = (state == DATA) && !full_iFIFO;
  assign data_push       = (state == DATA) && wdata_valid && !full_iFIFO;
  assign instr_push      = (state == INSTR) && !full_instFIFO;
  assign push_n_iFIFO    = !data_push;
  assign push_n_instFIFO = !instr_push;
  assign din_iFIFO       = wdata;
  assign din_instFIFO    = cmd_q;

  // Operand words go out ahead of their instruction so the core never
  // decodes an instruction whose data is still missing.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= IDLE;
      cnt       <= '0;
      cmd_q     <= '0;
      err_burst <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            cmd_q <= {cmd_instr, cmd_opcode};
            cnt   <= cnt_init;
            if (over) err_burst <= 1'b1;
            state <= (cnt_init != '0) ? DATA : INSTR;
          end
        end
        DATA: begin
          if (data_push) begin
            cnt <= cnt - 1'b1;
            if (cnt == NW'(1)) state <= INSTR;
          end
        end
        INSTR: begin
          if (instr_push) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Pop only when the holding register is free or being emptied this cycle.
  assign pop         = RST_N && !empty_oFIFO && (!rdata_valid || rdata_ready);
  assign pop_n_oFIFO = !pop;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rdata_valid <= 1'b0;
      rdata       <= '0;
    end else if (pop) begin
      rdata_valid <= 1'b1;
      rdata       <= dout_oFIFO;
    end else if (rdata_ready) begin
      rdata_valid <= 1'b0;
    end
  end

`ifdef RRAM_ISSUER_STATS_EN
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      stat_cmds  <= '0;
      stat_reads <= '0;
    end else begin
      if (instr_push) stat_cmds  <= stat_cmds + 32'd1;
      if (pop)        stat_reads <= stat_reads + 32'd1;
    end
  end
`else
  assign stat_cmds  = '0;
  assign stat_reads = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_rram_host_issuer.sv
// ============================================================================
// tb_rram_host_issuer -- scoreboard bench for rram_host_issuer.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_rram_host_issuer;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        cmd_valid, cmd_ready;
  logic [3:0]  cmd_instr;
  logic [15:0] cmd_opcode;
  logic [4:0]  cmd_nwords;
  logic        wdata_valid, wdata_ready;
  logic [63:0] wdata;
  logic        push_n_instFIFO, full_instFIFO;
  logic [19:0] din_instFIFO;
  logic        push_n_iFIFO, full_iFIFO;
  logic [63:0] din_iFIFO;
  logic        pop_n_oFIFO, empty_oFIFO;
  logic [63:0] dout_oFIFO;
  logic        rdata_valid, rdata_ready;
  logic [63:0] rdata;
  logic        busy, err_burst;
  logic [31:0] stat_cmds, stat_reads;

  rram_host_issuer dut (
    .CLK(CLK), .RST_N(RST_N),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_instr(cmd_instr),
    .cmd_opcode(cmd_opcode), .cmd_nwords(cmd_nwords),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
    .push_n_instFIFO(push_n_instFIFO), .full_instFIFO(full_instFIFO),
    .din_instFIFO(din_instFIFO),
    .push_n_iFIFO(push_n_iFIFO), .full_iFIFO(full_iFIFO), .din_iFIFO(din_iFIFO),
    .pop_n_oFIFO(pop_n_oFIFO), .empty_oFIFO(empty_oFIFO), .dout_oFIFO(dout_oFIFO),
    .rdata_valid(rdata_valid), .rdata_ready(rdata_ready), .rdata(rdata),
    .busy(busy), .err_burst(err_burst),
    .stat_cmds(stat_cmds), .stat_reads(stat_reads)
  );

  always #5 CLK = ~CLK;

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;
  int model_cmds  = 0;
  int model_reads = 0;

  logic [63:0] exp_data[$];
  logic [19:0] exp_instr[$];
  logic [63:0] exp_rq[$];
  logic [63:0] ofifo[$];
  logic [63:0] wbuf[0:19];
  bit          prev_stall = 1'b0;
  logic [63:0] prev_rdata = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic fail_event(input string name);
    n_total++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  always @(posedge CLK) cyc <= cyc + 1;

  // Output-FIFO model: first-word fall-through, head refreshed after each edge.
  always @(posedge CLK) begin
    logic [63:0] tmp;
    if (!pop_n_oFIFO && ofifo.size() > 0) begin
      tmp = ofifo.pop_front();
      model_reads++;
    end
    #1;
    empty_oFIFO = (ofifo.size() == 0);
    dout_oFIFO  = (ofifo.size() > 0) ? ofifo[0] : 64'd0;
  end

  // Monitor: compares everything the DUT presents against the scoreboard.
  always @(negedge CLK) begin
    if (RST_N) begin
      if (!push_n_iFIFO) begin
        if (exp_data.size() == 0) fail_event("unexpected iFIFO push");
        else check("iFIFO_word", din_iFIFO, exp_data.pop_front());
      end
      if (full_iFIFO) begin
        check("no_push_iFIFO_full", 64'(push_n_iFIFO), 64'd1);
        check("wdata_ready_full", 64'(wdata_ready), 64'd0);
      end
      if (!push_n_instFIFO) begin
        model_cmds++;
        if (exp_instr.size() == 0) fail_event("unexpected instFIFO push");
        else check("instFIFO_word", 64'(din_instFIFO), 64'(exp_instr.pop_front()));
      end
      if (full_instFIFO) check("no_push_instFIFO_full", 64'(push_n_instFIFO), 64'd1);
      if (empty_oFIFO) check("no_pop_empty", 64'(pop_n_oFIFO), 64'd1);
      if (prev_stall && rdata_valid) check("rdata_stable", rdata, prev_rdata);
      if (rdata_valid && rdata_ready) begin
        if (exp_rq.size() == 0) fail_event("unexpected rdata");
        else check("rdata_word", rdata, exp_rq.pop_front());
      end
      prev_stall = rdata_valid && !rdata_ready;
      prev_rdata = rdata;
    end
  end

  task automatic do_cmd(input logic [3:0] ins, input logic [15:0] opc, input logic [4:0] nw,
                        input int nfeed, input int stall_at, input int stall_len,
                        input int ifull_len);
    int acc, i, st, k, guard;
    bit ok;
    for (int j = 0; j < nfeed; j++) exp_data.push_back(wbuf[j]);
    exp_instr.push_back({ins, opc});
    @(posedge CLK); #1;
    cmd_valid = 1'b1; cmd_instr = ins; cmd_opcode = opc; cmd_nwords = nw;
    guard = 0;
    @(negedge CLK);
    while (!cmd_ready && guard < 50) begin @(negedge CLK); guard++; end
    if (!cmd_ready) fail_event("cmd accept timeout");
    acc = cyc;
    @(posedge CLK); #1;
    cmd_valid = 1'b0;
    i = 0; st = 0; guard = 0;
    while (i < nfeed && guard < 200) begin
      wdata_valid = 1'b1;
      wdata       = wbuf[i];
      full_iFIFO  = (i == stall_at) && (st < stall_len);
      @(negedge CLK);
      if (full_iFIFO) st++;
      else if (wdata_ready) i++;
      guard++;
      @(posedge CLK); #1;
    end
    wdata_valid = 1'b0;
    full_iFIFO  = 1'b0;
    if (i < nfeed) fail_event("data feed timeout");
    k = 0; guard = 0; ok = 1'b0;
    while (guard < 200) begin
      full_instFIFO = (k < ifull_len);
      @(negedge CLK);
      if (!push_n_instFIFO) begin ok = 1'b1; break; end
      k++; guard++;
      @(posedge CLK); #1;
    end
    if (!ok) fail_event("instr push timeout");
    else if (stall_len == 0 && ifull_len == 0)
      check("instr_push_cycle", 64'(cyc - acc), 64'(nfeed + 1));
    @(posedge CLK); #1;
    full_instFIFO = 1'b0;
    @(negedge CLK);
    check("cmd_ready_after", 64'(cmd_ready), 64'd1);
    check("busy_after", 64'(busy), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_push_n_inst"}, 64'(push_n_instFIFO), 64'd1);
    check({tag, "_push_n_i"}, 64'(push_n_iFIFO), 64'd1);
    check({tag, "_pop_n_o"}, 64'(pop_n_oFIFO), 64'd1);
    check({tag, "_din_inst"}, 64'(din_instFIFO), 64'd0);
    check({tag, "_rdata"}, rdata, 64'd0);
    check({tag, "_rdata_valid"}, 64'(rdata_valid), 64'd0);
    check({tag, "_err_burst"}, 64'(err_burst), 64'd0);
    check({tag, "_stat_cmds"}, 64'(stat_cmds), 64'd0);
    check({tag, "_stat_reads"}, 64'(stat_reads), 64'd0);
  endtask

  task automatic check_stats(input string tag);
`ifdef RRAM_ISSUER_STATS_EN
    check({tag, "_stat_cmds"}, 64'(stat_cmds), 64'(model_cmds));
    check({tag, "_stat_reads"}, 64'(stat_reads), 64'(model_reads));
`else
    check({tag, "_stat_cmds"}, 64'(stat_cmds), 64'd0);
    check({tag, "_stat_reads"}, 64'(stat_reads), 64'd0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bit pat [0:4];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    RST_N = 1'b0; cmd_valid = 1'b0; cmd_instr = '0; cmd_opcode = '0; cmd_nwords = '0;
    wdata_valid = 1'b0; wdata = '0; full_instFIFO = 1'b0; full_iFIFO = 1'b0;
    empty_oFIFO = 1'b1; dout_oFIFO = '0; rdata_ready = 1'b0;
    #2;
    check_reset_outputs("reset");
    #10 RST_N = 1'b1;

    // Burst store of two words
    wbuf[0] = 64'hABCDABCD; wbuf[1] = 64'hEEEECCCC;
    do_cmd(4'd4, 16'h440A, 5'd2, 2, -1, 0, 0);
    // Zero-word command
    do_cmd(4'd4, 16'h0000, 5'd0, 0, -1, 0, 0);
    // Input FIFO full for 5 cycles after the first of three words
    wbuf[0] = 64'h11; wbuf[1] = 64'h22; wbuf[2] = 64'h33;
    do_cmd(4'd2, 16'h1234, 5'd3, 3, 1, 5, 0);
    // Instruction FIFO full for 4 cycles
    wbuf[0] = 64'hDEADBEEF;
    do_cmd(4'd3, 16'h0BEE, 5'd1, 1, -1, 0, 4);

    // Readback with ready pattern 1,0,0,1,1
    @(negedge CLK);
    for (int j = 1; j <= 3; j++) begin
      ofifo.push_back(64'(j));
      exp_rq.push_back(64'(j));
    end
    for (int p = 0; p < 5; p++) begin
      @(posedge CLK); #1;
      rdata_ready = pat[p];
    end
    repeat (6) @(posedge CLK);
    @(negedge CLK);
    check("readback_drained", 64'(exp_rq.size()), 64'd0);
    check("rdata_valid_idle", 64'(rdata_valid), 64'd0);

    // Oversized burst is clamped to 16 words
    for (int j = 0; j < 20; j++) wbuf[j] = 64'h1000 + 64'(j);
    do_cmd(4'd5, 16'h00F0, 5'd20, 16, -1, 0, 0);
    check("err_burst_set", 64'(err_burst), 64'd1);
    wbuf[0] = 64'h77;
    do_cmd(4'd1, 16'h0001, 5'd1, 1, -1, 0, 0);
    check("err_burst_sticky", 64'(err_burst), 64'd1);
    check_stats("pre_reset");

    // Reset during word 2 of 4, with a result held and another in oFIFO
    rdata_ready = 1'b0;
    @(negedge CLK);
    ofifo.push_back(64'h55); ofifo.push_back(64'h66);
    exp_rq.push_back(64'h55);
    repeat (3) @(posedge CLK);
    wbuf[0] = 64'hA0; wbuf[1] = 64'hA1;
    exp_data.push_back(wbuf[0]);
    @(posedge CLK); #1;
    cmd_valid = 1'b1; cmd_instr = 4'd7; cmd_opcode = 16'h7777; cmd_nwords = 5'd4;
    @(negedge CLK);
    @(posedge CLK); #1;
    cmd_valid = 1'b0; wdata_valid = 1'b1; wdata = wbuf[0];
    @(negedge CLK);
    @(posedge CLK); #1;
    wdata = wbuf[1];
    #2 RST_N = 1'b0;
    #1;
    check_reset_outputs("midburst");
    check("oFIFO_nonempty_in_reset", 64'(empty_oFIFO), 64'd0);
    exp_rq.delete();
    exp_rq.push_back(64'h66);
    prev_stall  = 1'b0;
    model_cmds  = 0;
    model_reads = 0;
    wdata_valid = 1'b0;
    @(negedge CLK); #3;
    RST_N = 1'b1;
    rdata_ready = 1'b1;

    wbuf[0] = 64'hC0FFEE; wbuf[1] = 64'hBADC0DE;
    do_cmd(4'd6, 16'h6666, 5'd2, 2, -1, 0, 0);
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("post_reset_rdata_drained", 64'(exp_rq.size()), 64'd0);
    check_stats("post_reset");
    check("data_queue_drained", 64'(exp_data.size()), 64'd0);
    check("instr_queue_drained", 64'(exp_instr.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
